// File: rtl/latch_deserializer.sv
// Purpose: collects strobed latch bits into WIDTH-bit words; optional LATCH_DESER_SYNC_EN adds en/d synchronizers with rising-edge strobe detect.
// Latency: word is visible the cycle after its completing sample (sync build adds 3 cycles from raw en rise to sample).
// Backpressure: one-word holding register; a word completing while it is full and not consumed is dropped and sets sticky overrun.
module latch_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       d,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun,
    output logic [$clog2(WIDTH):0]     bit_cnt
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             samp;
    logic             samp_dat;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;
    logic             word_done;

`ifdef LATCH_DESER_SYNC_EN
    logic en_s1, en_s2, en_s3;
    logic d_s1, d_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_s1 <= 1'b0;
            en_s2 <= 1'b0;
            en_s3 <= 1'b0;
            d_s1  <= 1'b0;
            d_s2  <= 1'b0;
        end else begin
            en_s1 <= en;
            en_s2 <= en_s1;
            en_s3 <= en_s2;
            d_s1  <= d;
            d_s2  <= d_s1;
        end
    end

    // one sample per synchronized rising edge, however long en stays high
    assign samp     = en_s2 & ~en_s3;
    assign samp_dat = d_s2;
`else
    assign samp     = en;
    assign samp_dat = d;
`endif

    // the incoming bit always enters at the end opposite to where the first bit will finish
    assign shift_nxt = MSB_FIRST ? {shift_q[WIDTH-2:0], samp_dat}
                                 : {samp_dat, shift_q[WIDTH-1:1]};
    assign word_done = samp && (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (samp) begin
                shift_q <= shift_nxt;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end

            if (word_done && (!out_valid || out_ready)) begin
                out_data  <= shift_nxt;
                out_valid <= 1'b1;
            end else if (word_done) begin
                overrun   <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_latch_deserializer.sv
// Directed bench for latch_deserializer: MSB-first and LSB-first instances share stimulus.
// Build with LATCH_DESER_SYNC_EN defined to exercise the synchronized strobe path instead.
module tb_latch_deserializer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       d;
    logic       out_ready;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ovr, b_ovr;
    logic [3:0] a_cnt, b_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    latch_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d),
        .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
        .overrun(a_ovr), .bit_cnt(a_cnt)
    );

    latch_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d),
        .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
        .overrun(b_ovr), .bit_cnt(b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sends bits w[7] down to w[8-n] on consecutive cycles, leaves en low afterwards
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            en = 1'b1;
            d  = w[i];
            tick();
        end
        en = 1'b0;
        d  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        d         = 1'b0;
        out_ready = 1'b0;

        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_valid", {31'd0, a_valid}, 32'd0);
            chk("rst_data",  {24'd0, a_data},  32'd0);
            chk("rst_ovr",   {31'd0, a_ovr},   32'd0);
            chk("rst_cnt",   {28'd0, a_cnt},   32'd0);
        end
        rst_n = 1'b1;

`ifdef LATCH_DESER_SYNC_EN
        en = 1'b1;
        d  = 1'b1;
        tick();
        chk("sync_cnt_c1", {28'd0, a_cnt}, 32'd0);
        tick();
        chk("sync_cnt_c2", {28'd0, a_cnt}, 32'd0);
        tick();
        chk("sync_cnt_c3", {28'd0, a_cnt}, 32'd1);
        tick();
        chk("sync_cnt_c4", {28'd0, a_cnt}, 32'd1);
        en = 1'b0;
        repeat (4) tick();
        chk("sync_cnt_hold", {28'd0, a_cnt}, 32'd1);
        chk("sync_cnt_lsb",  {28'd0, b_cnt}, 32'd1);
`else
        // first word, both bit orders
        send_bits(8'hB2, 7);
        chk("w1_cnt7",   {28'd0, a_cnt},   32'd7);
        chk("w1_valid7", {31'd0, a_valid}, 32'd0);
        en = 1'b1; d = 1'b0; tick(); en = 1'b0;
        chk("w1_msb_data", {24'd0, a_data},  32'hB2);
        chk("w1_lsb_data", {24'd0, b_data},  32'h4D);
        chk("w1_valid",    {31'd0, a_valid}, 32'd1);
        chk("w1_cnt0",     {28'd0, a_cnt},   32'd0);

        // second word while stalled is dropped
        send_bits(8'hFF, 8);
        chk("ovr_data",     {24'd0, a_data},  32'hB2);
        chk("ovr_lsb_data", {24'd0, b_data},  32'h4D);
        chk("ovr_flag",     {31'd0, a_ovr},   32'd1);
        chk("ovr_valid",    {31'd0, a_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ovr_drain_valid", {31'd0, a_valid}, 32'd0);
        chk("ovr_sticky",      {31'd0, a_ovr},   32'd1);
        chk("ovr_data_hold",   {24'd0, a_data},  32'hB2);

        // completion coincides with consumption
        do_reset(1);
        chk("rst2_ovr", {31'd0, a_ovr}, 32'd0);
        send_bits(8'h11, 8);
        chk("sim_first", {24'd0, a_data}, 32'h11);
        send_bits(8'h22, 7);
        chk("sim_stall_data", {24'd0, a_data}, 32'h11);
        out_ready = 1'b1;
        en = 1'b1; d = 1'b0; tick(); en = 1'b0;
        chk("sim_data",     {24'd0, a_data},  32'h22);
        chk("sim_lsb_data", {24'd0, b_data},  32'h44);
        chk("sim_valid",    {31'd0, a_valid}, 32'd1);
        chk("sim_ovr",      {31'd0, a_ovr},   32'd0);
        tick();
        chk("sim_drain", {31'd0, a_valid}, 32'd0);
        out_ready = 1'b0;

        // partial word discarded by reset
        send_bits(8'hFF, 5);
        chk("mid_cnt5", {28'd0, a_cnt}, 32'd5);
        do_reset(1);
        chk("mid_cnt0", {28'd0, a_cnt}, 32'd0);
        send_bits(8'h96, 8);
        chk("mid_data",     {24'd0, a_data},  32'h96);
        chk("mid_lsb_data", {24'd0, b_data},  32'h69);
        chk("mid_valid",    {31'd0, a_valid}, 32'd1);

        // back-to-back words with a consumer always ready
        out_ready = 1'b1;
        tick();
        send_bits(8'h5A, 8);
        chk("b2b_w1", {24'd0, a_data}, 32'h5A);
        send_bits(8'hC3, 8);
        chk("b2b_w2",     {24'd0, a_data},  32'hC3);
        chk("b2b_lsb_w2", {24'd0, b_data},  32'hC3);
        chk("b2b_ovr",    {31'd0, a_ovr},   32'd0);
        chk("b2b_valid",  {31'd0, a_valid}, 32'd1);
        out_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
